control_seq: RTL
================

Name: control_seq

Overview:
- Parametrised, clocked successor to the accumulator-CPU instruction control unit.
- Holds a registered program counter and decodes the opcode into datapath strobes.
- Adds absolute jump and conditional branch on accumulator-zero, a HALT state, run-enable freeze, and a configurable data-RAM read latency with wait states.
- Sits between program memory (asynchronous read at o_Addr) and the accumulator/ALU/data-RAM datapath.

Parameters:
- NBITS_O, 11: operand width and program-counter width.
- NBITS_D, 16: instruction width. Must equal OPCODE+NBITS_O.
- OPCODE, 5: opcode field width, taken from instruction bits [NBITS_D-1:NBITS_O].
- RAM_LAT, 1: data-RAM read latency in cycles. Legal range 0..7.

Ports:
- i_clk, input, 1: single system clock. Rising edge.
- i_reset, input, 1: asynchronous, active-low reset.
- i_Instruction, input, NBITS_D: instruction fetched at o_Addr.
- i_Enable, input, 1: run enable. Low freezes the block.
- i_AccZero, input, 1: accumulator == 0 flag from the datapath.
- o_Addr, output, NBITS_O: program counter.
- o_Operand, output, NBITS_O: instruction[NBITS_O-1:0].
- o_SelA, output, 2: accumulator input mux. 00 = RAM data, 01 = immediate, 10 = ALU result.
- o_SelB, output, 1: ALU operand B. 0 = RAM data, 1 = immediate.
- o_Op, output, 1: ALU operation. 0 = add, 1 = subtract.
- o_WrAcc, output, 1: accumulator write strobe.
- o_WrRam, output, 1: data-RAM write strobe.
- o_RdRam, output, 1: data-RAM read strobe.
- o_Halt, output, 1: high in the HALT state.
- o_Busy, output, 1: high while in the WAIT state.

Behaviour:
- Reset (i_reset=0, asynchronous):
  - pc=0, state=RUN, wait counter=0.
  - All strobes, o_Halt and o_Busy are 0 while reset is asserted.
  - o_Addr=0. o_Operand follows the instruction.
- Opcode map:
  - 00000 HLT.
  - 00001 STO: WrRam.
  - 00010 LD: RdRam, SelA=00, WrAcc.
  - 00011 LDI: SelA=01, WrAcc.
  - 00100 ADD: RdRam, SelA=10, SelB=0, Op=0, WrAcc.
  - 00101 ADDI: SelA=10, SelB=1, Op=0, WrAcc.
  - 00110 SUB: as ADD with Op=1.
  - 00111 SUBI: as ADDI with Op=1.
  - 01000 BEQ.
  - 01001 BNE.
  - 01010 JMP.
  - All other opcodes are NOP: no strobes, pc+1.
  - Mux selects are don't-care when unused. Drive them to 0.
- States:
  - RUN: strobes are decoded combinationally from the current instruction.
  - WAIT: RAM-read stall.
  - HALT.
- RUN, single-cycle instructions (STO, LDI, ADDI, SUBI, NOP, and LD/ADD/SUB when RAM_LAT=0):
  - Strobes assert in the same cycle.
  - pc updates at the next edge.
  - Instruction latency is 1 cycle.
- RUN, RAM-read instructions with RAM_LAT>0:
  - o_RdRam=1 and o_WrAcc=0.
  - Next state is WAIT with counter=RAM_LAT. pc holds.
- WAIT:
  - o_RdRam=1 and o_Busy=1. SelA/SelB/Op stay decoded.
  - Counter decrements each enabled cycle.
  - When counter==1: o_WrAcc=1, pc increments at the edge, next state is RUN.
  - Total latency is RAM_LAT+1 cycles.
- Branches, resolved in one cycle with no strobes:
  - JMP: pc=operand.
  - BEQ: pc=operand if i_AccZero=1, else pc+1.
  - BNE: pc=operand if i_AccZero=0, else pc+1.
- pc+1 wraps modulo 2^NBITS_O. For example 0x7FF becomes 0x000 at NBITS_O=11.
- HLT:
  - Next state is HALT. pc holds at the HLT address.
  - In HALT, o_Halt=1 and all strobes are 0.
  - HALT is left only by reset.
- i_Enable=0 in any state:
  - WrAcc, WrRam and RdRam are forced to 0.
  - pc, state and counter hold.
  - o_Busy/o_Halt keep reflecting the state.
  - Re-asserting i_Enable resumes the operation exactly where it stopped, including the remaining wait count.
- Reset mid-WAIT or in HALT: immediate return to pc=0, RUN, with no spurious strobe.
- o_Addr is a register output with no combinational path from i_Instruction.

Test Plan:
- Reset then program LDI 5, ADDI 3, STO 0x010, HLT, RAM_LAT=1 -> o_Addr steps 0,1,2,3 over 4 cycles. ADDI cycle has SelA=10, SelB=1, Op=0. STO has WrRam=1 with operand 0x010. o_Halt=1 from cycle 4, o_Addr stays 3.
- LD 0x020 with RAM_LAT=3 -> RdRam high 4 cycles, o_Busy high 3 cycles, WrAcc exactly 1 cycle (the 4th), pc advances once.
- BEQ 0x100 with i_AccZero=1 -> o_Addr=0x100. Same with i_AccZero=0 -> pc+1. BNE gives the inverse. JMP 0x7FF then NOP -> o_Addr 0x7FF then 0x000 (wrap).
- i_Enable=0 for 2 cycles during WAIT of SUB (RAM_LAT=2) -> strobes 0, counter held, o_Busy=1. After re-enable, WrAcc with Op=1 fires once, total 5 cycles.
- Async reset asserted mid-WAIT and in HALT, off clock edge -> o_Addr=0, all strobes/o_Halt/o_Busy 0 immediately. After release, fetch resumes at address 0.
- Undefined opcode 11111 -> no strobes, pc+1.

Source files
------------

// File: rtl/control_seq_if.sv
// Program-memory / datapath bus of the instruction control unit.
// The master side is the program memory plus datapath; the slave side is control_seq.
interface control_seq_if #(
    parameter int NBITS_O = 11,
    parameter int NBITS_D = 16
);
    logic [NBITS_D-1:0] i_Instruction;
    logic               i_Enable;
    logic               i_AccZero;
    logic [NBITS_O-1:0] o_Addr;
    logic [NBITS_O-1:0] o_Operand;
    logic [1:0]         o_SelA;
    logic               o_SelB;
    logic               o_Op;
    logic               o_WrAcc;
    logic               o_WrRam;
    logic               o_RdRam;
    logic               o_Halt;
    logic               o_Busy;
    logic [1:0]         o_State;

    modport master (
        output i_Instruction, i_Enable, i_AccZero,
        input  o_Addr, o_Operand, o_SelA, o_SelB, o_Op,
        input  o_WrAcc, o_WrRam, o_RdRam, o_Halt, o_Busy, o_State
    );

    modport slave (
        input  i_Instruction, i_Enable, i_AccZero,
        output o_Addr, o_Operand, o_SelA, o_SelB, o_Op,
        output o_WrAcc, o_WrRam, o_RdRam, o_Halt, o_Busy, o_State
    );
endinterface

// File: rtl/control_seq.sv
// Accumulator-CPU control unit: registered PC, opcode decode into datapath strobes,
// branches, HALT, run-enable freeze and RAM-read wait states.
module control_seq #(
    parameter int NBITS_O = 11,
    parameter int NBITS_D = 16,
    parameter int OPCODE  = 5,
    parameter int RAM_LAT = 1
) (
    input  logic i_clk,
    input  logic i_reset,
    control_seq_if.slave bus
);
    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    localparam logic [OPCODE-1:0] OP_HLT  = OPCODE'(0);
    localparam logic [OPCODE-1:0] OP_STO  = OPCODE'(1);
    localparam logic [OPCODE-1:0] OP_LD   = OPCODE'(2);
    localparam logic [OPCODE-1:0] OP_LDI  = OPCODE'(3);
    localparam logic [OPCODE-1:0] OP_ADD  = OPCODE'(4);
    localparam logic [OPCODE-1:0] OP_ADDI = OPCODE'(5);
    localparam logic [OPCODE-1:0] OP_SUB  = OPCODE'(6);
    localparam logic [OPCODE-1:0] OP_SUBI = OPCODE'(7);
    localparam logic [OPCODE-1:0] OP_BEQ  = OPCODE'(8);
    localparam logic [OPCODE-1:0] OP_BNE  = OPCODE'(9);
    localparam logic [OPCODE-1:0] OP_JMP  = OPCODE'(10);

    localparam logic [2:0]         LAT    = 3'(RAM_LAT);
    localparam logic [NBITS_O-1:0] PC_ONE = NBITS_O'(1);

    logic [NBITS_O-1:0] pc_q, pc_d, pc_inc, operand;
    logic [1:0]         state_q, state_d;
    logic [2:0]         cnt_q, cnt_d;
    logic [OPCODE-1:0]  opcode;
    logic [1:0]         sel_a;
    logic               sel_b, op, wr_acc, wr_ram, rd_ram, run;

    assign opcode  = bus.i_Instruction[NBITS_D-1:NBITS_O];
    assign operand = bus.i_Instruction[NBITS_O-1:0];
    assign pc_inc  = pc_q + PC_ONE;
    // Reset is folded in so no strobe can glitch high while reset is held.
    assign run     = bus.i_Enable & i_reset;

    always_comb begin
        pc_d    = pc_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_a   = 2'b00;
        sel_b   = 1'b0;
        op      = 1'b0;
        wr_acc  = 1'b0;
        wr_ram  = 1'b0;
        rd_ram  = 1'b0;

        // Mux selects stay decoded through WAIT and while frozen; the held
        // instruction at pc is still the RAM-read one.
        if (i_reset && state_q != ST_HALT) begin
            case (opcode)
                OP_LDI:           sel_a = 2'b01;
                OP_ADD, OP_SUB:   sel_a = 2'b10;
                OP_ADDI, OP_SUBI: begin
                    sel_a = 2'b10;
                    sel_b = 1'b1;
                end
                default:          sel_a = 2'b00;
            endcase
            op = (opcode == OP_SUB) || (opcode == OP_SUBI);
        end

        if (run) begin
            case (state_q)
                ST_RUN: begin
                    case (opcode)
                        OP_HLT: state_d = ST_HALT;
                        OP_STO: begin
                            wr_ram = 1'b1;
                            pc_d   = pc_inc;
                        end
                        OP_LDI, OP_ADDI, OP_SUBI: begin
                            wr_acc = 1'b1;
                            pc_d   = pc_inc;
                        end
                        OP_LD, OP_ADD, OP_SUB: begin
                            rd_ram = 1'b1;
                            if (LAT == 3'd0) begin
                                wr_acc = 1'b1;
                                pc_d   = pc_inc;
                            end else begin
                                state_d = ST_WAIT;
                                cnt_d   = LAT;
                            end
                        end
                        OP_BEQ:  pc_d = bus.i_AccZero ? operand : pc_inc;
                        OP_BNE:  pc_d = bus.i_AccZero ? pc_inc : operand;
                        OP_JMP:  pc_d = operand;
                        default: pc_d = pc_inc;
                    endcase
                end
                ST_WAIT: begin
                    rd_ram = 1'b1;
                    if (cnt_q == 3'd1) begin
                        wr_acc  = 1'b1;
                        pc_d    = pc_inc;
                        state_d = ST_RUN;
                        cnt_d   = 3'd0;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            pc_q    <= '0;
            state_q <= ST_RUN;
            cnt_q   <= 3'd0;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.o_Addr    = pc_q;
    assign bus.o_Operand = operand;
    assign bus.o_SelA    = sel_a;
    assign bus.o_SelB    = sel_b;
    assign bus.o_Op      = op;
    assign bus.o_WrAcc   = wr_acc;
    assign bus.o_WrRam   = wr_ram;
    assign bus.o_RdRam   = rd_ram;
    assign bus.o_Halt    = (state_q == ST_HALT);
    assign bus.o_Busy    = (state_q == ST_WAIT);
    assign bus.o_State   = state_q;
endmodule
